// File: rtl/gray_pkg.sv
// Purpose : shared Gray-code helpers for the gray_counter slice.
// Latency : n/a (constants and pure functions only).
// Backpr. : n/a.
//
// Contents: GRAY_DEF_WIDTH (default counter width), GRAY_MAX_W (widest
// operand the helpers accept), bin2gray and gray2bin. Callers zero-extend
// narrower values to GRAY_MAX_W and truncate the result. Zero upper bits
// pass through both transforms unchanged, so the truncation is exact.
package gray_pkg;

  localparam int GRAY_DEF_WIDTH = 4;
  localparam int GRAY_MAX_W     = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

  // Prefix XOR from the MSB down: each binary bit is the parity of all
  // Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] i_gray);
    logic [GRAY_MAX_W-1:0] w_acc;
    w_acc[GRAY_MAX_W-1] = i_gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      w_acc[i] = w_acc[i+1] ^ i_gray[i];
    end
    return w_acc;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Purpose : combinational Gray -> binary decoder for the counter load path.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; output follows input continuously.
//
// Ports: i_gray [WIDTH] Gray-coded value in; o_bin [WIDTH] binary value out.
// WIDTH must not exceed gray_pkg::GRAY_MAX_W.
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_bin = WIDTH'(gray2bin(GRAY_MAX_W'(i_gray)));

endmodule

// File: rtl/gray_counter.sv
// Purpose : registered up/down Gray counter with synchronous Gray load.
// Latency : 1 cycle from load/en to g, b and g_vld; tc is combinational.
// Backpr. : none; one step per enabled cycle, load has priority over en.
//
// Ports:
//   clk    rising-edge clock        rst_n  async active-low reset
//   en     count enable             up     1 = increment, 0 = decrement
//   load   sync load strobe         g_in   Gray-coded load value [WIDTH]
//   g      registered Gray count    b      registered binary count
//   tc     terminal count (next enabled step wraps/saturates)
//   g_vld  one-cycle pulse: g changed on the last edge
// Build option: define GRAY_CNT_SAT_EN to saturate at the ends instead of
// wrapping modulo 2^WIDTH.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH   = GRAY_DEF_WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
  output logic             tc,
  output logic             g_vld
);

  localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_G = RST_B ^ (RST_B >> 1);
  localparam logic [WIDTH-1:0] MAX_B = '1;
  localparam logic [WIDTH-1:0] ONE_B = WIDTH'(1);

  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_g;
  logic             r_g_vld;

  logic [WIDTH-1:0] w_load_b;
  logic [WIDTH-1:0] w_step_b;
  logic [WIDTH-1:0] w_nxt_b;
  logic [WIDTH-1:0] w_nxt_g;
  logic             w_nxt_vld;
  logic             w_tc;
  logic             w_step_ok;

  gray_to_binary #(
    .WIDTH (WIDTH)
  ) u_load_dec (
    .i_gray (g_in),
    .o_bin  (w_load_b)
  );

  // tc looks at the registered count and the live direction only, so it
  // flags the boundary even while en is low.
  assign w_tc = up ? (r_b == MAX_B) : (r_b == '0);

`ifdef GRAY_CNT_SAT_EN
  // At the boundary the count step is suppressed entirely (no g_vld).
  assign w_step_ok = !w_tc;
`else
  assign w_step_ok = 1'b1;
`endif

  always_comb begin
    w_step_b  = up ? (r_b + ONE_B) : (r_b - ONE_B);
    w_nxt_b   = r_b;
    w_nxt_g   = r_g;
    w_nxt_vld = 1'b0;
    if (load) begin
      w_nxt_b   = w_load_b;
      w_nxt_g   = g_in;
      w_nxt_vld = (g_in != r_g);
    end else if (en && w_step_ok) begin
      // g is derived from the next binary value so it never lags b.
      w_nxt_b   = w_step_b;
      w_nxt_g   = WIDTH'(bin2gray(GRAY_MAX_W'(w_step_b)));
      w_nxt_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b     <= RST_B;
      r_g     <= RST_G;
      r_g_vld <= 1'b0;
    end else begin
      r_b     <= w_nxt_b;
      r_g     <= w_nxt_g;
      r_g_vld <= w_nxt_vld;
    end
  end

  assign g     = r_g;
  assign b     = r_b;
  assign tc    = w_tc;
  assign g_vld = r_g_vld;

endmodule
